// File: rtl/pc_gen_if.sv
// Fetch-PC control bundle between branch/hazard logic (master) and pc_gen (slave).
interface pc_gen_if #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall_i;
  logic             trap_i;
  logic             redirect_i;
  logic [PC_W-1:0]  redirect_pc_i;
  logic             call_i;
  logic [PC_W-1:0]  link_pc_i;
  logic             ret_i;
  logic [PC_W-1:0]  ret_pc_i;
  logic [PC_W-1:0]  pc_o;
  logic [CNT_W-1:0] ras_count_o;
  logic             ras_empty_o;
  logic             ras_full_o;

  modport master (
    output stall_i, trap_i, redirect_i, redirect_pc_i,
    output call_i, link_pc_i, ret_i, ret_pc_i,
    input  pc_o, ras_count_o, ras_empty_o, ras_full_o
  );

  modport slave (
    input  stall_i, trap_i, redirect_i, redirect_pc_i,
    input  call_i, link_pc_i, ret_i, ret_pc_i,
    output pc_o, ras_count_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: trap > redirect > return > stall > sequential.
// Optional return-address stack built when PC_RAS_EN is defined.
module pc_gen #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [31:0]     TRAP_VEC  = 32'h0000_0080,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  pc_gen_if.slave bus
);
  localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [PC_W-1:0] TRAP_PC = PC_W'(TRAP_VEC);
  localparam logic [PC_W-1:0] INC_PC  = PC_W'(INC);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ret_tgt;

`ifdef PC_RAS_EN
  localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec, wr_ptr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, full_q;
  logic             wr_en;

  // Circular pointer neighbours; depth need not be a power of two.
  assign top_inc = (top_q == PTR_MAX) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_MAX : top_q - PTR_W'(1);
  assign ret_tgt = (cnt_q != '0) ? ras_q[top_q] : bus.ret_pc_i;

  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = top_q;
    if (bus.trap_i) begin
      top_d = '0;
      cnt_d = '0;
    end else if (bus.call_i && (bus.redirect_i || !bus.ret_i)) begin
      // Push; a call rides along with its own redirect. Full stack drops oldest.
      wr_en  = 1'b1;
      wr_ptr = top_inc;
      top_d  = top_inc;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (bus.redirect_i) begin
      top_d = top_q;
    end else if (bus.call_i && bus.ret_i) begin
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (bus.ret_i && (cnt_q != '0)) begin
      top_d = top_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_MAX);
    end
  end

  // Stack storage carries no reset; contents are meaningless while count is 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) ras_q[wr_ptr] <= bus.link_pc_i;
  end

  assign bus.ras_count_o = cnt_q;
  assign bus.ras_empty_o = empty_q;
  assign bus.ras_full_o  = full_q;
`else
  logic unused_c;

  assign ret_tgt         = bus.ret_pc_i;
  assign unused_c        = ^{bus.call_i, bus.link_pc_i};
  assign bus.ras_count_o = '0;
  assign bus.ras_empty_o = 1'b1;
  assign bus.ras_full_o  = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q + INC_PC;
    if (bus.trap_i)          pc_d = TRAP_PC;
    else if (bus.redirect_i) pc_d = bus.redirect_pc_i;
    else if (bus.ret_i)      pc_d = ret_tgt;
    else if (bus.stall_i)    pc_d = pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end

  assign bus.pc_o = pc_q;
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined CPU fetch stage; successor to the plain registered PC. Holds the fetch PC and selects the next PC each cycle by fixed priority: trap, redirect, return, sequential. Supports stall and an optional return-address stack (RAS) for call/return prediction. Sits between the branch/hazard logic and instruction memory.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- PC_W, 32, PC and address width in bits.
- RESET_VEC, 0, value loaded into pc_o by reset.
- TRAP_VEC, 32'h0000_0080, value loaded on trap; truncated to PC_W.
- INC, 4, sequential increment.
- RAS_DEPTH, 4, RAS entries (≥2); ignored without PC_RAS_EN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- stall_i  in  1  hold pc_o; suppresses the sequential increment only.
- trap_i  in  1  jump to TRAP_VEC.
- redirect_i  in  1  branch/jump taken.
- redirect_pc_i  in  PC_W  redirect target.
- call_i  in  1  push link_pc_i onto the RAS.
- link_pc_i  in  PC_W  return address to push.
- ret_i  in  1  return; jump to the popped RAS top.
- ret_pc_i  in  PC_W  fallback return target (RAS empty or RAS absent).
- pc_o  out  PC_W  current fetch PC, registered.
- ras_count_o  out  $clog2(RAS_DEPTH+1)  valid RAS entries; 0 without PC_RAS_EN.
- ras_empty_o  out  1  ras_count_o == 0.
- ras_full_o  out  1  ras_count_o == RAS_DEPTH; 0 without PC_RAS_EN.

## Operation
- Next PC priority:
  - trap_i → TRAP_VEC.
  - else redirect_i → redirect_pc_i.
  - else ret_i → RAS top if non-empty, otherwise ret_pc_i.
  - else stall_i → hold.
  - else pc_o + INC.
- trap_i, redirect_i and ret_i override stall_i.
- Sequential add is modulo 2^PC_W: all-ones-region PC wraps to low addresses; no carry out.
- RAS is circular storage with a top pointer and a saturating count.
- Push (call_i alone): write link_pc_i at top+1, advance top, count+1.
- Push when full: overwrite the oldest entry; count stays RAS_DEPTH.
- Pop (ret_i alone): the target is the current top; retreat top, count−1.
- Pop when empty: no pointer or count change; the target is ret_pc_i.
- call_i and ret_i together: the target is the current top (ret_pc_i if empty); the top entry is replaced by link_pc_i in place; count unchanged, or 1 if it was empty.
- RAS push/pop happen whenever call_i/ret_i are asserted, regardless of stall_i.
- RAS push/pop are suppressed when trap_i or redirect_i is asserted. Exception: call_i with redirect_i still pushes, because a call is a taken jump.
- trap_i flushes the RAS: count = 0, top pointer = 0.

## Timing
- All state updates on the rising clk_i edge. Next PC is combinational from the inputs; pc_o is visible one cycle after the inputs are sampled.
- A push is visible to a pop in the immediately following cycle; there is no bypass within the same cycle.
- Reset (rst_i high at an edge): pc_o = RESET_VEC, ras_count_o = 0, ras_empty_o = 1, ras_full_o = 0, top pointer = 0. RAS data contents are don't-care.
- Reset overrides every other input, including a redirect or RAS operation in the same cycle.
- Reset asserted mid-stall or mid-call sequence discards all pending state. The first post-reset fetch is RESET_VEC, held for exactly the reset cycles plus 0 extra cycles.

## Configuration
- PC_RAS_EN defined: RAS built as described. ret_i uses the RAS top, with ret_pc_i as fallback when empty.
- PC_RAS_EN undefined: no RAS storage.
  - ret_i always jumps to ret_pc_i; call_i only has effect through redirect_i.
  - ras_count_o = 0, ras_empty_o = 1, ras_full_o = 0 constantly.

## Test plan
- Reset then free-run, PC_W=32, RESET_VEC=0x100: pc_o = 0x100, 0x104, 0x108 on successive cycles. Assert stall_i for 2 cycles → pc_o holds 0x108 for 2 cycles.
- Priority: trap_i, redirect_i (0x400) and ret_i asserted together with stall_i → pc_o = 0x80 next cycle, and ras_count_o = 0.
- RAS_DEPTH=4, PC_RAS_EN:
  - Push links 0x10, 0x20, 0x30, 0x40, 0x50 → ras_full_o = 1, count = 4.
  - Four ret_i pulses give pc_o = 0x50, 0x40, 0x30, 0x20.
  - A fifth ret_i gives ret_pc_i (0x999) with ras_empty_o = 1.
- Simultaneous call_i (link 0x60) and ret_i with top 0x20 → pc_o = 0x20, count unchanged. The next ret_i → pc_o = 0x60.
- Wrap: PC_W=16, pc_o = 0xFFFC, no control inputs → pc_o = 0x0000.
- Without PC_RAS_EN: call_i 0x10 then ret_i with ret_pc_i = 0x77 → pc_o = 0x77; ras_count_o stays 0.
